// File: rtl/pll_reset_sequencer.sv
// Purpose : sequences SDRAM and system resets from the PLL lock indicator.
// Latency : locked -> state change 3 edges (2-flop sync + 1 registered edge); outputs change with state.
// Backpressure: none; pure control block, outputs are levels.
//
// Ports:
//   clock         in   sequencer clock (50 MHz PLL IO clock)
//   reset_n       in   asynchronous active-low reset
//   locked        in   PLL lock indicator, asynchronous to clock
//   sw_reset      in   synchronous soft-reset request, level-sensitive
//   sdram_rst     out  active-high reset for SDRAM controller / SDRAM clock domains
//   sys_rst       out  active-high reset for CPU and IO logic
//   ready         out  high only in RUN
//   state         out  current state (0 WAIT_LOCK, 1 STABLE, 2 SDRAM_HOLD, 3 RUN)
//   lock_loss_cnt out  saturating count of lock losses after SDRAM release

module pll_reset_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int SDRAM_HOLD    = 256
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       sw_reset,
  output logic       sdram_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK  = 2'd0,
    ST_STABLE     = 2'd1,
    ST_SDRAM_HOLD = 2'd2,
    ST_RUN        = 2'd3
  } seqState_t;

  // Terminal counter values: the transition happens on the cycle the counter
  // reaches N-1, so exactly N cycles are spent in the counting state.
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(SDRAM_HOLD - 1);

  // Two-flop synchronizer for the asynchronous lock indicator.
  logic syncMeta;
  logic lockedS;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      syncMeta <= 1'b0;
      lockedS  <= 1'b0;
    end else begin
      syncMeta <= locked;
      lockedS  <= syncMeta;
    end
  end

  seqState_t   curState;
  seqState_t   nextState;
  logic [15:0] cycleCnt;
  logic [15:0] nextCnt;
  logic        lossEvent;

  // Next-state decode. Priority: lock loss, then soft reset, then counter
  // terminal. The counter is cleared on every state change.
  always_comb begin
    nextState = curState;
    nextCnt   = cycleCnt;
    lossEvent = 1'b0;
    case (curState)
      ST_WAIT_LOCK: begin
        nextCnt = 16'd0;
        if (lockedS) begin
          nextState = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (!lockedS) begin
          nextState = ST_WAIT_LOCK;
          nextCnt   = 16'd0;
        end else if (sw_reset) begin
          // Restart the stability window without leaving STABLE.
          nextCnt = 16'd0;
        end else if (cycleCnt == STABLE_LAST) begin
          nextState = ST_SDRAM_HOLD;
          nextCnt   = 16'd0;
        end else begin
          nextCnt = cycleCnt + 16'd1;
        end
      end
      ST_SDRAM_HOLD: begin
        if (!lockedS) begin
          nextState = ST_WAIT_LOCK;
          nextCnt   = 16'd0;
          lossEvent = 1'b1;
        end else if (sw_reset) begin
          nextState = ST_STABLE;
          nextCnt   = 16'd0;
        end else if (cycleCnt == HOLD_LAST) begin
          nextState = ST_RUN;
          nextCnt   = 16'd0;
        end else begin
          nextCnt = cycleCnt + 16'd1;
        end
      end
      ST_RUN: begin
        nextCnt = 16'd0;
        if (!lockedS) begin
          nextState = ST_WAIT_LOCK;
          lossEvent = 1'b1;
        end else if (sw_reset) begin
          nextState = ST_STABLE;
        end
      end
      default: begin
        nextState = ST_WAIT_LOCK;
        nextCnt   = 16'd0;
      end
    endcase
  end

  // State, counter and outputs. Outputs decode nextState so they switch on
  // the same edge as the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      curState      <= ST_WAIT_LOCK;
      cycleCnt      <= 16'd0;
      sdram_rst     <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      curState  <= nextState;
      cycleCnt  <= nextCnt;
      sdram_rst <= (nextState == ST_WAIT_LOCK) || (nextState == ST_STABLE);
      sys_rst   <= (nextState != ST_RUN);
      ready     <= (nextState == ST_RUN);
      if (lossEvent && (lock_loss_cnt != 8'hFF)) begin
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
    end
  end

  assign state = curState;

  // The system domain must never leave reset while SDRAM is still held.
  sysAfterSdram: assert property (@(posedge clock) disable iff (!reset_n)
    !(sdram_rst && !sys_rst));

endmodule
